// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Brief    : Shared types and configuration checks for the sequential
//             magnitude comparator.
//  Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    // Controller states; 2-bit encoding, DONE is a single-cycle state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal configuration: slice fits inside the operand and divides it
    function automatic bit cfg_legal(input int width, input int slice);
        return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_slice
//  Brief    : Combinational eq/gt cascade stage. A slice can only flip the
//             result while everything above it has compared equal.
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_slice #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] sa,
    input  logic [SLICE-1:0] sb,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             eq_out,
    output logic             gt_out
);

    // Once a higher slice has decided, gt is frozen and eq stays low
    assign gt_out = gt_in | (eq_in & (sa > sb));
    assign eq_out = eq_in & (sa == sb);

endmodule
`default_nettype wire

// File: rtl/seq_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mag_comparator
//  Brief    : Multi-cycle MSB-first magnitude comparator, SLICE bits per
//             clock, signed/unsigned mode, start/done handshake and early
//             termination as soon as a slice differs.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Flipping the sign bit of both operands turns two's-complement order
    // into plain unsigned order, so one datapath serves both modes.
    localparam logic [WIDTH-1:0] c_msb_mask = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    c_last_cnt = CW'(NSLICE - 1);

    generate
        if (!cfg_legal(WIDTH, SLICE)) begin : g_bad_cfg
            $error("seq_mag_comparator: WIDTH must be a multiple of SLICE and SLICE in 1..WIDTH");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_eq_c;
    logic             r_gt_c;
    logic [CW-1:0]    r_cnt;
    logic             w_eq_nxt;
    logic             w_gt_nxt;
    logic             w_last;

    cmp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .sa     (r_a[WIDTH-1 -: SLICE]),
        .sb     (r_b[WIDTH-1 -: SLICE]),
        .eq_in  (r_eq_c),
        .gt_in  (r_gt_c),
        .eq_out (w_eq_nxt),
        .gt_out (w_gt_nxt)
    );

    // Terminate on the first differing slice or after the last slice
    assign w_last = (~w_eq_nxt) | (r_cnt == c_last_cnt);

    // Controller, operand shifters, cascade state and registered results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_eq_c  <= 1'b1;
            r_gt_c  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a ^ (signed_mode ? c_msb_mask : '0);
                        r_b     <= b ^ (signed_mode ? c_msb_mask : '0);
                        r_eq_c  <= 1'b1;
                        r_gt_c  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here: no restart, no reload
                    r_eq_c <= w_eq_nxt;
                    r_gt_c <= w_gt_nxt;
                    r_a    <= r_a << SLICE;
                    r_b    <= r_b << SLICE;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        eq      <= w_eq_nxt;
                        gt      <= w_gt_nxt;
                        lt      <= ~w_eq_nxt & ~w_gt_nxt;
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mag_comparator
//  Brief    : Directed self-checking bench for seq_mag_comparator (8/2 main
//             instance plus 16-bit instances with slice widths 1, 4, 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mag_comparator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, eq, gt, lt;

    logic        start16 = 1'b0;
    logic        mode16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16 [3];
    logic        done16 [3];
    logic        eq16   [3];
    logic        gt16   [3];
    logic        lt16   [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(8), .SLICE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    seq_mag_comparator #(.WIDTH(16), .SLICE(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(mode16),
        .a(a16), .b(b16), .busy(busy16[0]), .done(done16[0]),
        .eq(eq16[0]), .gt(gt16[0]), .lt(lt16[0])
    );

    seq_mag_comparator #(.WIDTH(16), .SLICE(4)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(mode16),
        .a(a16), .b(b16), .busy(busy16[1]), .done(done16[1]),
        .eq(eq16[1]), .gt(gt16[1]), .lt(lt16[1])
    );

    seq_mag_comparator #(.WIDTH(16), .SLICE(16)) u_dut_s16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(mode16),
        .a(a16), .b(b16), .busy(busy16[2]), .done(done16[2]),
        .eq(eq16[2]), .gt(gt16[2]), .lt(lt16[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns at the negedge after that edge
    task automatic pulse_start(input logic [7:0] va, input logic [7:0] vb, input logic m);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; signed_mode = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample at negedges until done, counting busy cycles; bounded
    task automatic wait_done(output int busy_cyc, output logic ok);
        busy_cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    function automatic int exp_k(input logic [15:0] va, input logic [15:0] vb, input int s);
        logic [15:0] x;
        x = va ^ vb;
        for (int p = 0; p < 16; p++)
            if (x[15-p]) return p / s + 1;
        return 16 / s;
    endfunction

    task automatic sweep(input logic [15:0] va, input logic [15:0] vb, input logic m);
        int          kgot [3];
        logic [2:0]  rgot [3];
        logic [2:0]  rexp;
        int          sl [3];
        bit          all;
        sl[0] = 1; sl[1] = 4; sl[2] = 16;
        if (va == vb)                                   rexp = 3'b100;
        else if (m ? ($signed(va) > $signed(vb)) : (va > vb)) rexp = 3'b010;
        else                                            rexp = 3'b001;
        @(negedge clk);
        start16 = 1'b1; a16 = va; b16 = vb; mode16 = m;
        @(negedge clk);
        start16 = 1'b0;
        for (int j = 0; j < 3; j++) begin kgot[j] = -1; rgot[j] = 3'b000; end
        for (int n = 1; n <= 40; n++) begin
            all = 1'b1;
            for (int j = 0; j < 3; j++) begin
                if (done16[j] && kgot[j] < 0) begin
                    kgot[j] = n - 1;
                    rgot[j] = {eq16[j], gt16[j], lt16[j]};
                end
                if (kgot[j] < 0) all = 1'b0;
            end
            if (all) break;
            @(negedge clk);
        end
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("sw_res a=%h b=%h m=%0d s=%0d", va, vb, m, sl[j]), {29'd0, rgot[j]}, {29'd0, rexp});
            chk($sformatf("sw_k a=%h b=%h m=%0d s=%0d", va, vb, m, sl[j]), kgot[j], exp_k(va, vb, sl[j]));
        end
    endtask

    initial begin
        int   bc;
        logic ok;
        bit   saw;

        repeat (3) @(negedge clk);
        chk("reset_outs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        rst_n = 1'b1;

        // Equal operands: all four slices evaluated
        pulse_start(8'hA5, 8'hA5, 1'b0);
        wait_done(bc, ok);
        chk("eq_done", ok, 1);
        chk("eq_busy", bc, 4);
        chk("eq_res", {eq, gt, lt}, 3'b100);
        @(negedge clk);
        chk("eq_pulse", done, 0);

        // Early exit at the first slice
        pulse_start(8'hC0, 8'h3F, 1'b0);
        wait_done(bc, ok);
        chk("early_done", ok, 1);
        chk("early_busy", bc, 1);
        chk("early_res", {eq, gt, lt}, 3'b010);

        // Signed versus unsigned interpretation
        pulse_start(8'h80, 8'h7F, 1'b1);
        wait_done(bc, ok);
        chk("signed_res", {ok, eq, gt, lt}, 4'b1001);
        chk("signed_busy", bc, 1);
        pulse_start(8'h80, 8'h7F, 1'b0);
        wait_done(bc, ok);
        chk("unsigned_res", {ok, eq, gt, lt}, 4'b1010);

        // start during RUN must be ignored
        pulse_start(8'h01, 8'h01, 1'b0);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, ok);
        chk("ign_done", ok, 1);
        chk("ign_busy", bc + 1, 4);
        chk("ign_res", {eq, gt, lt}, 3'b100);
        saw = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (done) saw = 1'b1;
            @(negedge clk);
        end
        chk("ign_no_extra_done", saw, 0);

        // Back-to-back: second request issued during the DONE cycle
        pulse_start(8'h30, 8'h10, 1'b0);
        wait_done(bc, ok);
        chk("b2b_first", {ok, eq, gt, lt}, 4'b1010);
        start = 1'b1; a = 8'h10; b = 8'h20; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_done", {busy, done}, 2'b10);
        wait_done(bc, ok);
        chk("b2b_second", {ok, eq, gt, lt}, 4'b1001);
        chk("b2b_busy", bc, 2);
        @(negedge clk);
        chk("b2b_single_pulse", done, 0);

        // Reset in the middle of a compare
        pulse_start(8'h00, 8'h03, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_outs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        chk("rst_mid_quiet", {saw, eq, gt, lt}, 4'b0000);
        pulse_start(8'h05, 8'h04, 1'b0);
        wait_done(bc, ok);
        chk("rst_after_res", {ok, eq, gt, lt}, 4'b1010);
        chk("rst_after_busy", bc, 4);

        // 16-bit sweep across slice widths, both modes
        sweep(16'h1234, 16'h1234, 1'b0);
        sweep(16'h8000, 16'h7FFF, 1'b1);
        sweep(16'h8000, 16'h7FFF, 1'b0);
        sweep(16'h00F0, 16'h00E0, 1'b0);
        sweep(16'hFFFF, 16'hFFFE, 1'b1);
        sweep(16'h0001, 16'h0000, 1'b0);
        sweep(16'hFF00, 16'h0100, 1'b1);
        for (int i = 0; i < 6; i++)
            sweep(16'($urandom), 16'($urandom), 1'(i & 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator; next generation of the team's 2-bit cascadable compare slice.
- Compares two WIDTH-bit operands MSB-first, SLICE bits per clock, using the same eq/gt cascade rule as the slice.
- Adds a signed/unsigned mode, a start/done handshake and early termination once the result is decided.
- Used by datapath control (sort/min-max units) where a full-width combinational comparator would miss timing.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of SLICE.
- SLICE, 2, bits compared per clock; must be 1..WIDTH.
- NSLICE, WIDTH/SLICE, derived; maximum number of compare cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; operands are sampled on the same edge.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.

Behaviour:
- Reset:
  - Clock and reset are decided: one clock; reset is synchronous and active-low.
  - While rst_n=0 at a clock edge: state goes to IDLE and busy, done, eq, gt, lt all go to 0.
  - Reset mid-RUN aborts the compare, no done pulse is produced, and the outputs do not change afterwards.
- States: IDLE, RUN, DONE (enum in package).
- IDLE/DONE with start=1 at an edge:
  - Latch a_r=a, b_r=b.
  - If signed_mode=1, invert the MSB of both a_r and b_r; this maps signed order onto unsigned order.
  - Set cascade eq_c=1, gt_c=0, slice counter=0, and go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN, each edge:
  - Take the top SLICE bits of a_r and b_r and apply the slice rule: gt_c' = gt_c | (eq_c & sa>sb); eq_c' = eq_c & (sa==sb).
  - Shift a_r and b_r left by SLICE and increment the counter.
  - If eq_c'=0 (decided) or counter = NSLICE-1: register eq=eq_c', gt=gt_c', lt=~eq_c' & ~gt_c', and go to DONE.
- Latency:
  - start sampled at edge e0; slices evaluated at e1..ek, with k <= NSLICE.
  - done is high for exactly the cycle after ek; k is the index of the first differing slice, or NSLICE when the operands are equal.
- start while in RUN is ignored: no restart and no operand reload.
- start during the DONE cycle is accepted (back-to-back operation); done still pulses only that one cycle.
- eq/gt/lt hold their last values until the next done; exactly one of them is 1 after the first completion.
- busy=1 exactly while state==RUN; done=1 exactly while state==DONE.

Decomposition:
- Package cmp_pkg: state enum (IDLE, RUN, DONE) and the parameter-legality check (WIDTH % SLICE == 0).
- Sub-module cmp_slice #(SLICE): purely combinational; inputs sa, sb, eq_in, gt_in; outputs eq_out, gt_out (the cascade rule above).
- Top module holds the FSM, the shift registers, the counter and the result registers.

Test Plan:
- Equal operands: WIDTH=8, SLICE=2, unsigned, a=0xA5, b=0xA5 -> done in cycle after e4; eq=1, gt=0, lt=0; busy high for 4 cycles.
- Early exit: a=0xC0, b=0x3F, unsigned -> decided at e1; done in cycle after e1; gt=1; busy high for 1 cycle.
- Mode difference: a=0x80, b=0x7F -> signed_mode=1 gives lt=1 (-128<127); signed_mode=0 gives gt=1 (128>127).
- Start while busy: start with a=0x01, b=0x01, then pulse start with a=0xFF, b=0x00 during RUN -> ignored; done after e4 with eq=1.
- Back-to-back: second start (a=0x10, b=0x20) in the DONE cycle -> busy next cycle; second done shows lt=1; exactly one done per request.
- Reset mid-RUN: rst_n=0 at e2 -> all outputs 0 and state IDLE; no done pulse; a subsequent start works normally.
- Parameter sweep: WIDTH=16 with SLICE=1, 4 and 16, random operands in both modes -> results match a reference compare; cycle count matches the first differing slice.
